helppll_loopfilter: RTL and testbench
=====================================

Name: helppll_loopfilter

Overview:
- Digital PI loop filter downstream of the helper-clock frequency comparator.
- Consumes the signed frequency-difference word and its strobe, both in the reference clock domain.
- Produces a saturated unsigned control word for the helper-oscillator DAC, with a valid/ready handshake toward the DAC serial driver.
- Also provides lock detection, a startup-sample skip, a dropped-sample counter and a debug view of the integrator.

Parameters:
- DWIDTH, 32, width of the freqdiff input.
- DACW, 16, DAC control word width (unsigned).
- IWIDTH, 40, signed integrator width.
- OUT_SHR, 4, arithmetic right shift applied to the (P+I) sum before the offset is added.
- ERRLIM, 4095, symmetric clamp applied to freqdiff.
- SKIP, 2, number of strobes ignored after reset or after enable rises.
- LOCKN, 8, consecutive in-threshold samples required to assert locked.

Ports:
- clk  in  1  reference clock (same domain as the freqdiff producer).
- areset  in  1  asynchronous, active-high reset.
- enable  in  1  loop enable.
- freqdiff  in  DWIDTH  signed (help − ref) count difference.
- stb_freqdiff  in  1  single-cycle strobe; freqdiff is valid on this cycle.
- kp_shl  in  4  proportional gain, 2^kp_shl.
- ki_shl  in  4  integral gain, 2^ki_shl.
- offset  in  DACW  DAC centre value.
- lock_thresh  in  16  lock window on |err|.
- dac_data  out  DACW  control word; stable while dac_valid is high.
- dac_valid  out  1  control word offered to the DAC driver.
- dac_ready  in  1  DAC driver accepts; transfer occurs when valid&ready.
- locked  out  1  lock indicator.
- dropped_cnt  out  16  saturating count of strobes arriving while busy.
- integ_dbg  out  IWIDTH  integrator value.

Behaviour:
- Reset (async, areset=1): all of the following are cleared to 0: dac_data, dac_valid, locked, dropped_cnt, integ, skip counter, lock counter, rail flags. State goes to IDLE.
- States: IDLE, CALC, SUM, SEND, CENTER.

IDLE:
- A strobe with enable=1 and skip counter < SKIP increments the skip counter and is otherwise ignored.
- A strobe with enable=1 and skip counter ≥ SKIP latches err = clamp(freqdiff, −ERRLIM, +ERRLIM), then goes to CALC.
- A strobe with enable=0 is ignored.

CALC (1 cycle):
- p = −err·2^kp_shl, computed at IWIDTH.
- inc = −err·2^ki_shl.
- Anti-windup: if the previous dac_data was at 2^DACW−1 and inc>0, hold integ. If it was at 0 and inc<0, hold integ.
- Otherwise integ ← integ+inc, saturated to ±(2^(IWIDTH−1)−1).
- Lock: if |err| ≤ lock_thresh, the lock counter increments (saturating at LOCKN) and locked=1 once it reaches LOCKN. Otherwise the lock counter and locked clear in this cycle.

SUM (1 cycle):
- s = offset + ((p+integ) >>> OUT_SHR), arithmetic shift (floor).
- dac_data = clamp(s, 0, 2^DACW−1).
- dac_valid ← 1, state → SEND.
- Latency: strobe at cycle t gives dac_valid=1 at t+3.

SEND:
- Hold dac_data and dac_valid until dac_ready=1.
- On that cycle dac_valid ← 0 and state → IDLE.
- dac_ready sampled while dac_valid=0 has no effect.

Busy handling:
- A strobe in any state other than IDLE is dropped.
- dropped_cnt increments by 1, saturating at 0xFFFF; integ is unaffected.
- A strobe arriving on the same cycle as the SEND→IDLE transfer is also dropped.

Enable falling edge (any state):
- integ, lock counter, locked and skip counter clear; state → CENTER.
- In CENTER: dac_data = offset, dac_valid=1, wait for dac_ready, then IDLE.
- A transfer pending in SEND is abandoned (dac_valid stays 1 but dac_data becomes offset).
- Enable rising restarts the skip sequence.

Arithmetic:
- All intermediate sums are sign-extended to IWIDTH+2 bits before clamping; no wraparound is permitted anywhere.

Test Plan:
1. Reset, enable=1, three strobes with freqdiff=10 and dac_ready tied high → first two ignored (no dac_valid). Third, with offset=32768, kp_shl=4, ki_shl=2, OUT_SHR=4: p=−160, integ=−40, dac_data=32755, dac_valid at t+3.
2. freqdiff=+100000 → err clamped to 4095. With offset=65000, repeated negative freqdiff drives dac_data to 65535 and it stays there; integ_dbg stops increasing once the rail is hit (anti-windup).
3. dac_ready held low for 20 cycles after dac_valid, with 2 strobes during the wait → dac_data stable, dropped_cnt=2, integ unchanged by the dropped strobes. Release ready → single transfer.
4. lock_thresh=5: 8 strobes with freqdiff=3 → locked rises on the 8th. One strobe with freqdiff=−6 → locked=0 on the CALC cycle.
5. enable dropped mid-SEND → dac_data=offset, integ_dbg=0, locked=0. Re-enable → the next two strobes are ignored.
6. areset asserted while dac_valid=1 → dac_valid and all outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/helppll_loopfilter.sv
`default_nettype none
// ============================================================================
// Module  : helppll_loopfilter
// Brief   : PI loop filter turning the helper-clock frequency error into a
//           saturated DAC control word offered over a valid/ready handshake.
// Revision: 1.0
// ============================================================================
module helppll_loopfilter #(
   parameter int DWIDTH  = 32,
   parameter int DACW    = 16,
   parameter int IWIDTH  = 40,
   parameter int OUT_SHR = 4,
   parameter int ERRLIM  = 4095,
   parameter int SKIP    = 2,
   parameter int LOCKN   = 8
) (
   input  logic              clk,
   input  logic              areset,
   input  logic              enable,
   input  logic [DWIDTH-1:0] freqdiff,
   input  logic              stb_freqdiff,
   input  logic [3:0]        kp_shl,
   input  logic [3:0]        ki_shl,
   input  logic [DACW-1:0]   offset,
   input  logic [15:0]       lock_thresh,
   output logic [DACW-1:0]   dac_data,
   output logic              dac_valid,
   input  logic              dac_ready,
   output logic              locked,
   output logic [15:0]       dropped_cnt,
   output logic [IWIDTH-1:0] integ_dbg
);
   localparam int W2  = IWIDTH + 2;
   localparam int SKW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
   localparam int LKW = $clog2(LOCKN + 1);
   localparam logic signed [W2-1:0]     IMAX   = W2'({1'b0, {(IWIDTH-1){1'b1}}});
   localparam logic signed [W2-1:0]     IMIN   = -IMAX;
   localparam logic signed [W2-1:0]     DMAX   = W2'({DACW{1'b1}});
   localparam logic signed [DWIDTH-1:0] ELIM_P = DWIDTH'(ERRLIM);
   localparam logic signed [DWIDTH-1:0] ELIM_N = -ELIM_P;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CALC   = 3'd1,
      S_SUM    = 3'd2,
      S_SEND   = 3'd3,
      S_CENTER = 3'd4
   } state_t;

   state_t                    state_q, state_d;
   logic signed [DWIDTH-1:0]  err_q, err_d;
   logic signed [IWIDTH-1:0]  p_q, p_d;
   logic signed [IWIDTH-1:0]  integ_q, integ_d;
   logic [DACW-1:0]           dac_data_q, dac_data_d;
   logic                      dac_valid_q, dac_valid_d;
   logic                      locked_q, locked_d;
   logic [15:0]               dropped_q, dropped_d;
   logic [SKW-1:0]            skip_q, skip_d;
   logic [LKW-1:0]            lock_cnt_q, lock_cnt_d;
   logic                      rail_hi_q, rail_hi_d;
   logic                      rail_lo_q, rail_lo_d;
   logic                      enable_q, enable_d;

   logic signed [DWIDTH-1:0]  fd_s;
   logic [DWIDTH-1:0]         abs_err;
   logic signed [W2-1:0]      err_x, inc_x, isum_x, ps_x, s_x;
   logic [DACW-1:0]           dac_sat;
   logic                      hold;

   always_comb begin
      fd_s    = $signed(freqdiff);
      err_x   = W2'(err_q);
      inc_x   = (-err_x) <<< ki_shl;
      isum_x  = W2'(integ_q) + inc_x;
      ps_x    = W2'(p_q) + W2'(integ_q);
      s_x     = W2'($signed({1'b0, offset})) + (ps_x >>> OUT_SHR);
      abs_err = err_q[DWIDTH-1] ? -err_q : err_q;
      // Anti-windup: stop integrating further into a rail the output already sits on
      hold    = (rail_hi_q && !inc_x[W2-1] && (inc_x != '0)) ||
                (rail_lo_q && inc_x[W2-1]);
      if (s_x[W2-1])      dac_sat = '0;
      else if (s_x > DMAX) dac_sat = '1;
      else                 dac_sat = s_x[DACW-1:0];

      state_d     = state_q;
      err_d       = err_q;
      p_d         = p_q;
      integ_d     = integ_q;
      dac_data_d  = dac_data_q;
      dac_valid_d = dac_valid_q;
      locked_d    = locked_q;
      dropped_d   = dropped_q;
      skip_d      = skip_q;
      lock_cnt_d  = lock_cnt_q;
      rail_hi_d   = rail_hi_q;
      rail_lo_d   = rail_lo_q;
      enable_d    = enable;

      if (stb_freqdiff && (state_q != S_IDLE) && (dropped_q != 16'hFFFF))
         dropped_d = dropped_q + 16'd1;

      if (enable_q && !enable) begin
         integ_d     = '0;
         lock_cnt_d  = '0;
         locked_d    = 1'b0;
         skip_d      = '0;
         dac_data_d  = offset;
         dac_valid_d = 1'b1;
         rail_hi_d   = &offset;
         rail_lo_d   = ~|offset;
         state_d     = S_CENTER;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (stb_freqdiff && enable) begin
                  if (skip_q < SKW'(SKIP)) begin
                     skip_d = skip_q + SKW'(1);
                  end else begin
                     if (fd_s > ELIM_P)      err_d = ELIM_P;
                     else if (fd_s < ELIM_N) err_d = ELIM_N;
                     else                    err_d = fd_s;
                     state_d = S_CALC;
                  end
               end
            end
            S_CALC: begin
               p_d = IWIDTH'((-err_x) <<< kp_shl);
               if (!hold) begin
                  if (isum_x > IMAX)      integ_d = IWIDTH'(IMAX);
                  else if (isum_x < IMIN) integ_d = IWIDTH'(IMIN);
                  else                    integ_d = IWIDTH'(isum_x);
               end
               if (abs_err <= DWIDTH'(lock_thresh)) begin
                  if (lock_cnt_q != LKW'(LOCKN)) lock_cnt_d = lock_cnt_q + LKW'(1);
                  locked_d = (lock_cnt_q >= LKW'(LOCKN - 1));
               end else begin
                  lock_cnt_d = '0;
                  locked_d   = 1'b0;
               end
               state_d = S_SUM;
            end
            S_SUM: begin
               dac_data_d  = dac_sat;
               dac_valid_d = 1'b1;
               rail_hi_d   = &dac_sat;
               rail_lo_d   = ~|dac_sat;
               state_d     = S_SEND;
            end
            S_SEND, S_CENTER: begin
               if (dac_ready) begin
                  dac_valid_d = 1'b0;
                  state_d     = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q     <= S_IDLE;
         err_q       <= '0;
         p_q         <= '0;
         integ_q     <= '0;
         dac_data_q  <= '0;
         dac_valid_q <= 1'b0;
         locked_q    <= 1'b0;
         dropped_q   <= '0;
         skip_q      <= '0;
         lock_cnt_q  <= '0;
         rail_hi_q   <= 1'b0;
         rail_lo_q   <= 1'b0;
         enable_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         err_q       <= err_d;
         p_q         <= p_d;
         integ_q     <= integ_d;
         dac_data_q  <= dac_data_d;
         dac_valid_q <= dac_valid_d;
         locked_q    <= locked_d;
         dropped_q   <= dropped_d;
         skip_q      <= skip_d;
         lock_cnt_q  <= lock_cnt_d;
         rail_hi_q   <= rail_hi_d;
         rail_lo_q   <= rail_lo_d;
         enable_q    <= enable_d;
      end
   end

   assign dac_data    = dac_data_q;
   assign dac_valid   = dac_valid_q;
   assign locked      = locked_q;
   assign dropped_cnt = dropped_q;
   assign integ_dbg   = integ_q;

endmodule
`default_nettype wire

// File: tb/tb_helppll_loopfilter.sv
`default_nettype none
// ============================================================================
// Module  : tb_helppll_loopfilter
// Brief   : Scenario-driven bench for the helper PLL loop filter with a
//           behavioural model feeding an expected-DAC-word queue.
// Revision: 1.0
// ============================================================================
module tb_helppll_loopfilter;
   logic        clk = 1'b0;
   logic        areset, enable, stb_freqdiff, dac_ready;
   logic [31:0] freqdiff;
   logic [3:0]  kp_shl, ki_shl;
   logic [15:0] offset, lock_thresh;
   logic [15:0] dac_data, dropped_cnt;
   logic        dac_valid, locked;
   logic [39:0] integ_dbg;

   int errors = 0;
   int checks = 0;

   longint      m_integ;
   int          m_skip, m_lock, m_drop;
   bit          m_busy, m_rhi, m_rlo;
   logic [15:0] sb[$];

   always #5 clk = ~clk;

   helppll_loopfilter dut (
      .clk(clk), .areset(areset), .enable(enable), .freqdiff(freqdiff),
      .stb_freqdiff(stb_freqdiff), .kp_shl(kp_shl), .ki_shl(ki_shl),
      .offset(offset), .lock_thresh(lock_thresh), .dac_data(dac_data),
      .dac_valid(dac_valid), .dac_ready(dac_ready), .locked(locked),
      .dropped_cnt(dropped_cnt), .integ_dbg(integ_dbg)
   );

   function automatic longint floor16(input longint x);
      longint r;
      r = x % 16;
      if (r < 0) r = r + 16;
      return (x - r) / 16;
   endfunction

   task automatic model_reset();
      m_integ = 0; m_skip = 0; m_lock = 0; m_drop = 0;
      m_busy = 0; m_rhi = 0; m_rlo = 0;
      sb.delete();
   endtask

   task automatic model_strobe(input longint fd);
      longint err, p, inc, s, imax;
      logic [15:0] d;
      imax = (longint'(1) <<< 39) - 1;
      if (m_busy) begin
         if (m_drop < 65535) m_drop++;
      end else if (enable) begin
         if (m_skip < 2) m_skip++;
         else begin
            err = (fd > 4095) ? 4095 : ((fd < -4095) ? -4095 : fd);
            p   = -err * (longint'(1) << kp_shl);
            inc = -err * (longint'(1) << ki_shl);
            if (!((m_rhi && inc > 0) || (m_rlo && inc < 0))) begin
               m_integ = m_integ + inc;
               if (m_integ > imax) m_integ = imax;
               if (m_integ < -imax) m_integ = -imax;
            end
            s = longint'(offset) + floor16(p + m_integ);
            d = (s < 0) ? 16'd0 : ((s > 65535) ? 16'hFFFF : s[15:0]);
            m_rhi = (d == 16'hFFFF);
            m_rlo = (d == 16'd0);
            sb.push_back(d);
            m_busy = 1;
         end
      end
   endtask

   // One clock: scoreboard the handshake on the falling edge, return 1 after the rising edge
   task automatic step();
      logic [15:0] exp;
      @(negedge clk);
      if (dac_valid && dac_ready && !areset) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_transfer: got dac_data=%0d, expected no transfer", dac_data);
         end else begin
            exp = sb.pop_front();
            if (dac_data !== exp) begin
               errors++;
               $display("FAIL sb_dac_data: got %0d expected %0d", dac_data, exp);
            end
         end
         m_busy = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_strobe(input longint fd);
      freqdiff     = fd[31:0];
      stb_freqdiff = 1'b1;
      model_strobe(fd);
      step();
      stb_freqdiff = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (dac_data !== 16'd0)    begin errors++; $display("FAIL reset_dac_data: got %0d expected 0", dac_data); end
      checks++; if (dac_valid !== 1'b0)    begin errors++; $display("FAIL reset_dac_valid: got %0b expected 0", dac_valid); end
      checks++; if (locked !== 1'b0)       begin errors++; $display("FAIL reset_locked: got %0b expected 0", locked); end
      checks++; if (dropped_cnt !== 16'd0) begin errors++; $display("FAIL reset_dropped: got %0d expected 0", dropped_cnt); end
      checks++; if (integ_dbg !== 40'd0)   begin errors++; $display("FAIL reset_integ: got %0h expected 0", integ_dbg); end
      areset = 1'b0;
      step();
   endtask

   task automatic test_startup_skip();
      enable = 1'b1;
      step();
      for (int k = 0; k < 2; k++) begin
         do_strobe(10);
         repeat (3) step();
         checks++; if (dac_valid !== 1'b0) begin errors++; $display("FAIL skip_valid%0d: got %0b expected 0", k, dac_valid); end
         checks++; if (integ_dbg !== 40'd0) begin errors++; $display("FAIL skip_integ%0d: got %0h expected 0", k, integ_dbg); end
      end
      do_strobe(10);
      step();
      checks++; if (dac_valid !== 1'b0) begin errors++; $display("FAIL first_latency_early: got %0b expected 0", dac_valid); end
      checks++; if ($signed(integ_dbg) !== -40'sd40) begin errors++; $display("FAIL first_integ: got %0d expected -40", $signed(integ_dbg)); end
      step();
      checks++; if (dac_valid !== 1'b1) begin errors++; $display("FAIL first_latency: got %0b expected 1", dac_valid); end
      checks++; if (dac_data !== 16'd32755) begin errors++; $display("FAIL first_dac_data: got %0d expected 32755", dac_data); end
      step(); step();
      checks++; if (dac_valid !== 1'b0) begin errors++; $display("FAIL first_release: got %0b expected 0", dac_valid); end
   endtask

   task automatic test_saturation();
      offset = 16'd65000;
      do_strobe(100000);
      step(); step();
      checks++; if (dac_data !== 16'd59878) begin errors++; $display("FAIL clamp_pos_err: got %0d expected 59878", dac_data); end
      step(); step();
      for (int k = 0; k < 4; k++) begin
         do_strobe(-100000);
         step(); step();
         checks++; if (dac_data !== 16'hFFFF) begin errors++; $display("FAIL rail_hi%0d: got %0d expected 65535", k, dac_data); end
         checks++; if (integ_dbg !== m_integ[39:0]) begin errors++; $display("FAIL windup%0d: got %0d expected %0d", k, $signed(integ_dbg), m_integ); end
         step(); step();
      end
      checks++; if ($signed(integ_dbg) !== -40'sd40) begin errors++; $display("FAIL windup_final: got %0d expected -40", $signed(integ_dbg)); end
   endtask

   task automatic test_backpressure();
      offset    = 16'd32768;
      dac_ready = 1'b0;
      do_strobe(10);
      step(); step();
      checks++; if (dac_data !== 16'd32753) begin errors++; $display("FAIL bp_dac_data: got %0d expected 32753", dac_data); end
      for (int i = 0; i < 20; i++) begin
         if (i == 5 || i == 12) do_strobe(7);
         else step();
         checks++;
         if (dac_valid !== 1'b1 || dac_data !== 16'd32753) begin
            errors++;
            $display("FAIL bp_hold%0d: got valid=%0b data=%0d expected valid=1 data=32753", i, dac_valid, dac_data);
         end
      end
      checks++; if (dropped_cnt !== 16'd2) begin errors++; $display("FAIL bp_dropped: got %0d expected 2", dropped_cnt); end
      checks++; if (dropped_cnt !== m_drop[15:0]) begin errors++; $display("FAIL bp_dropped_model: got %0d expected %0d", dropped_cnt, m_drop); end
      checks++; if ($signed(integ_dbg) !== -40'sd80) begin errors++; $display("FAIL bp_integ: got %0d expected -80", $signed(integ_dbg)); end
      dac_ready = 1'b1;
      step();
      checks++; if (dac_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %0b expected 0", dac_valid); end
      repeat (3) step();
      checks++; if (dac_valid !== 1'b0) begin errors++; $display("FAIL bp_single: got %0b expected 0", dac_valid); end
   endtask

   task automatic test_lock();
      lock_thresh = 16'd5;
      for (int k = 1; k <= 8; k++) begin
         do_strobe(3);
         step();
         checks++; if (locked !== (k == 8)) begin errors++; $display("FAIL lock_count%0d: got %0b expected %0b", k, locked, (k == 8)); end
         repeat (3) step();
      end
      do_strobe(-6);
      step();
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_loss: got %0b expected 0", locked); end
      repeat (3) step();
   endtask

   task automatic test_enable_drop();
      offset    = 16'd30000;
      dac_ready = 1'b0;
      do_strobe(10);
      step(); step();
      checks++; if (dac_valid !== 1'b1) begin errors++; $display("FAIL ed_send: got %0b expected 1", dac_valid); end
      enable = 1'b0;
      sb.delete();
      sb.push_back(offset);
      m_integ = 0; m_lock = 0; m_skip = 0; m_busy = 1;
      m_rhi = (offset == 16'hFFFF); m_rlo = (offset == 16'd0);
      step();
      checks++; if (dac_valid !== 1'b1 || dac_data !== 16'd30000) begin errors++; $display("FAIL ed_center: got valid=%0b data=%0d expected valid=1 data=30000", dac_valid, dac_data); end
      checks++; if (integ_dbg !== 40'd0) begin errors++; $display("FAIL ed_integ: got %0d expected 0", $signed(integ_dbg)); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL ed_locked: got %0b expected 0", locked); end
      dac_ready = 1'b1;
      step();
      checks++; if (dac_valid !== 1'b0) begin errors++; $display("FAIL ed_center_release: got %0b expected 0", dac_valid); end
      enable = 1'b1;
      step();
      for (int k = 0; k < 2; k++) begin
         do_strobe(10);
         repeat (3) step();
         checks++; if (dac_valid !== 1'b0 || integ_dbg !== 40'd0) begin errors++; $display("FAIL ed_reskip%0d: got valid=%0b integ=%0d expected 0/0", k, dac_valid, $signed(integ_dbg)); end
      end
      do_strobe(10);
      step(); step();
      checks++; if (dac_valid !== 1'b1 || dac_data !== 16'd29987) begin errors++; $display("FAIL ed_resume: got valid=%0b data=%0d expected valid=1 data=29987", dac_valid, dac_data); end
      step(); step();
   endtask

   task automatic test_async_reset();
      dac_ready = 1'b0;
      do_strobe(10);
      step(); step();
      checks++; if (dac_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %0b expected 1", dac_valid); end
      #2;
      areset = 1'b1;
      #1;
      checks++; if (dac_valid !== 1'b0)    begin errors++; $display("FAIL ar_valid: got %0b expected 0", dac_valid); end
      checks++; if (dac_data !== 16'd0)    begin errors++; $display("FAIL ar_dac_data: got %0d expected 0", dac_data); end
      checks++; if (dropped_cnt !== 16'd0) begin errors++; $display("FAIL ar_dropped: got %0d expected 0", dropped_cnt); end
      checks++; if (integ_dbg !== 40'd0)   begin errors++; $display("FAIL ar_integ: got %0d expected 0", $signed(integ_dbg)); end
      checks++; if (locked !== 1'b0)       begin errors++; $display("FAIL ar_locked: got %0b expected 0", locked); end
      model_reset();
      step();
      areset = 1'b0;
      step();
   endtask

   initial begin
      areset = 1'b1; enable = 1'b0; stb_freqdiff = 1'b0; freqdiff = '0;
      kp_shl = 4'd4; ki_shl = 4'd2; offset = 16'd32768; lock_thresh = 16'd0;
      dac_ready = 1'b1;
      model_reset();
      test_reset();
      test_startup_skip();
      test_saturation();
      test_backpressure();
      test_lock();
      test_enable_drop();
      test_async_reset();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending words expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
